pkt_read_scheduler: RTL and testbench

//  Sequences read-out of the captured ADC sample memory into packets for the ADC_DATA pads.

---
 rtl/pkt_read_scheduler_if.sv | 29 ++
 rtl/pkt_read_scheduler.sv | 111 +++++++++++
 tb/tb_pkt_read_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pkt_read_scheduler_if.sv
// pkt_read_scheduler_if: regfile control, sample RAM read port and pad output bundle
interface pkt_read_scheduler_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 18,
  parameter int CNT_W  = 8
);
  logic              capture_start;
  logic              capture_again;
  logic [1:0]        cfg_data_length;
  logic [CNT_W-1:0]  cfg_idle_length;
  logic [CNT_W-1:0]  cfg_gap;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] adc_data;
  logic              adc_data_valid;
  logic              pkt_sop;
  logic              pkt_eop;
  logic              rd_done;
  logic              busy;
  modport master (
    input  capture_start, capture_again, cfg_data_length, cfg_idle_length, cfg_gap, mem_rdata,
    output mem_rd_en, mem_rd_addr, adc_data, adc_data_valid, pkt_sop, pkt_eop, rd_done, busy
  );
  modport slave (
    output capture_start, capture_again, cfg_data_length, cfg_idle_length, cfg_gap, mem_rdata,
    input  mem_rd_en, mem_rd_addr, adc_data, adc_data_valid, pkt_sop, pkt_eop, rd_done, busy
  );
endinterface

// File: rtl/pkt_read_scheduler.sv
// pkt_read_scheduler: frames sample RAM read-out into packets for the ADC_DATA pads (PKT_SCHED_FRAME_CNT_EN adds o_frame_cnt)
module pkt_read_scheduler #(
  parameter int ADDR_W    = 14,
  parameter int MEM_DEPTH = 13824,
  parameter int DATA_W    = 18,
  parameter int CNT_W     = 8,
  parameter int RD_LAT    = 1
) (
  input  logic clk,
  input  logic rstn,
`ifdef PKT_SCHED_FRAME_CNT_EN
  output logic [15:0] o_frame_cnt,
`endif
  pkt_read_scheduler_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_DATA, S_GAP, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  state_t            r_state, w_state_nxt, w_arm_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt, r_gap;
  logic [10:0]       r_wcnt, w_plen;
  logic [1:0]        r_len;
  logic              r_again;
  logic              w_arm, w_last_word, w_end_mem, w_rd_en, w_sop, w_eop;
  logic [2:0]        r_pipe [RD_LAT];
  logic              r_valid, r_sop, r_eop;
  logic [DATA_W-1:0] r_data;
  assign w_plen      = 11'd216 << r_len;
  assign w_last_word = r_wcnt == w_plen - 11'd1;
  assign w_end_mem   = r_addr == LAST;
  assign w_arm       = (r_state == S_IDLE && (bus.capture_start || bus.capture_again)) ||
                       (r_state == S_DONE && (r_again || bus.capture_again));
  assign w_arm_state = bus.cfg_idle_length == '0 ? S_DATA : S_LEAD;
  assign w_rd_en     = r_state == S_DATA;
  assign w_sop       = w_rd_en && r_wcnt == '0;
  assign w_eop       = w_rd_en && (w_last_word || w_end_mem);
  assign bus.mem_rd_en      = w_rd_en;
  assign bus.mem_rd_addr    = r_addr;
  assign bus.rd_done        = r_state == S_DONE;
  assign bus.busy           = r_state != S_IDLE;
  assign bus.adc_data       = r_data;
  assign bus.adc_data_valid = r_valid;
  assign bus.pkt_sop        = r_sop;
  assign bus.pkt_eop        = r_eop;
  // Next-state: lead-in, packet reads, inter-packet gap, one-cycle done with optional re-arm
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_arm ? w_arm_state : S_IDLE;
      S_LEAD:  w_state_nxt = r_cnt == CNT_W'(1) ? S_DATA : S_LEAD;
      S_DATA:  w_state_nxt = w_end_mem ? S_DONE : (w_last_word && r_gap != '0) ? S_GAP : S_DATA;
      S_GAP:   w_state_nxt = r_cnt == CNT_W'(1) ? S_DATA : S_GAP;
      S_DONE:  w_state_nxt = w_arm ? w_arm_state : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // State, config snapshot, address/word/idle counters and the re-arm flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_wcnt  <= '0;
      r_len   <= '0;
      r_again <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_again <= (r_state == S_IDLE || r_state == S_DONE) ? 1'b0 : r_again | bus.capture_again;
      if (w_arm) begin
        r_len  <= bus.cfg_data_length;
        r_gap  <= bus.cfg_gap;
        r_cnt  <= bus.cfg_idle_length;
        r_addr <= '0;
        r_wcnt <= '0;
      end else if (r_state == S_DATA) begin
        r_addr <= w_end_mem ? '0 : r_addr + 1'b1;
        r_wcnt <= w_last_word ? '0 : r_wcnt + 1'b1;
        r_cnt  <= r_gap;
      end else if (r_state == S_LEAD || r_state == S_GAP) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  // Delay strobe/framing by the RAM latency, then register them with the returned sample
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pipe[0] <= {w_rd_en, w_sop, w_eop};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_valid <= r_pipe[RD_LAT-1][2];
      r_sop   <= r_pipe[RD_LAT-1][1];
      r_eop   <= r_pipe[RD_LAT-1][0];
      r_data  <= r_pipe[RD_LAT-1][2] ? bus.mem_rdata : '0;
    end
  end
`ifdef PKT_SCHED_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  assign o_frame_cnt = r_frame_cnt;
  // Packets emitted in the current run, restarted whenever a run is armed
  always_ff @(posedge clk) begin
    if (!rstn || w_arm) r_frame_cnt <= '0;
    else if (r_pipe[RD_LAT-1][0]) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pkt_read_scheduler.sv
// tb_pkt_read_scheduler: scoreboard bench for the packet read scheduler
module tb_pkt_read_scheduler;
  localparam int DEPTH = 864;
  typedef struct {logic [17:0] d; logic s; logic e;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int checks = 0, errors = 0;
  int n_valid = 0, n_sop = 0, n_eop = 0, n_done = 0, done_cyc = 0, t0 = 0;
  exp_t sb[$];
  exp_t e_m;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pkt_read_scheduler_if #(.ADDR_W(14), .DATA_W(18), .CNT_W(8)) bus();
`ifdef PKT_SCHED_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  pkt_read_scheduler #(.ADDR_W(14), .MEM_DEPTH(DEPTH), .DATA_W(18), .CNT_W(8), .RD_LAT(1)) dut (
    .clk(clk),
    .rstn(rstn),
`ifdef PKT_SCHED_FRAME_CNT_EN
    .o_frame_cnt(frame_cnt),
`endif
    .bus(bus.master)
  );
  function automatic logic [17:0] pat(input logic [13:0] a);
    return {a[3:0], a} ^ 18'h15A5A;
  endfunction
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // One-cycle RAM model; returns junk when not read so ungated output data shows up
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? pat(bus.mem_rd_addr) : 18'h3FFFF;
  // Output monitor: pop and compare every valid word, require quiet outputs otherwise
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rd_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.adc_data_valid) begin
        n_valid++;
        n_sop += int'(bus.pkt_sop);
        n_eop += int'(bus.pkt_eop);
        if (sb.size() == 0) chk("sb_extra", 1, 0);
        else begin
          e_m = sb.pop_front();
          chk("data", bus.adc_data, e_m.d);
          chk("sop", bus.pkt_sop, e_m.s);
          chk("eop", bus.pkt_eop, e_m.e);
        end
      end else chk("idle_out", {bus.adc_data, bus.pkt_sop, bus.pkt_eop}, 0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    n_valid = 0; n_sop = 0; n_eop = 0; n_done = 0;
  endtask
  task automatic cfg(input int len, input int gap, input int idle);
    bus.cfg_data_length = 2'(len);
    bus.cfg_gap = 8'(gap);
    bus.cfg_idle_length = 8'(idle);
  endtask
  task automatic push_run(input int len);
    int plen;
    plen = 216 << len;
    for (int a = 0; a < DEPTH; a++)
      sb.push_back('{pat(14'(a)), (a % plen) == 0, (a % plen) == plen - 1 || a == DEPTH - 1});
  endtask
  task automatic pulse(input logic s, input logic a);
    bus.capture_start = s;
    bus.capture_again = a;
    tick();
    bus.capture_start = 1'b0;
    bus.capture_again = 1'b0;
  endtask
  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && n_done < n; i++) @(negedge clk);
    chk("done_wait", n_done >= n, 1);
    tick();
  endtask
  task automatic wait_addr(input int a, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      found = bus.mem_rd_en && bus.mem_rd_addr == 14'(a);
    end
    chk("addr_seen", found, 1);
    tick();
  endtask
  task automatic drain();
    repeat (6) tick();
    chk("sb_empty", sb.size(), 0);
  endtask
  initial begin
    bus.capture_start = 1'b0;
    bus.capture_again = 1'b0;
    cfg(0, 0, 0);
    repeat (3) tick();
    chk("rst_ctl", {bus.busy, bus.mem_rd_en, bus.rd_done, bus.adc_data_valid, bus.pkt_sop, bus.pkt_eop}, 0);
    chk("rst_addr", bus.mem_rd_addr, 0);
    chk("rst_data", bus.adc_data, 0);
    rstn = 1'b1;
    tick();
    // two 432-word packets, 1 lead-in cycle, 4-cycle gap
    clr(); cfg(1, 4, 1); push_run(1);
    t0 = cyc; pulse(1, 0);
    wait_done(1, 2000);
    chk("t1_dur", done_cyc - t0, 1 + 864 + 4 + 1);
    drain();
    chk("t1_valid", n_valid, 864); chk("t1_sop", n_sop, 2); chk("t1_eop", n_eop, 2);
    chk("t1_done", n_done, 1); chk("t1_busy", bus.busy, 0);
    // packet longer than memory: one truncated packet, no gap
    clr(); cfg(3, 4, 0); push_run(3);
    t0 = cyc; pulse(1, 0);
    wait_done(1, 2000);
    chk("t2_dur", done_cyc - t0, 865);
    drain();
    chk("t2_valid", n_valid, 864); chk("t2_sop", n_sop, 1); chk("t2_eop", n_eop, 1);
    // re-arm mid-run, second pulse in the same run collapses into one
    clr(); cfg(0, 2, 3); push_run(0); push_run(0);
    t0 = cyc; pulse(1, 0);
    wait_addr(100, 2000); pulse(0, 1);
    wait_addr(500, 2000); pulse(0, 1);
    wait_done(2, 4000);
    chk("t3_dur", done_cyc - t0, 2 * (3 + 864 + 3 * 2 + 1));
    drain();
    repeat (1000) tick();
    chk("t3_valid", n_valid, 1728); chk("t3_done", n_done, 2); chk("t3_busy", bus.busy, 0);
    // start while busy is ignored
    clr(); cfg(1, 0, 2); push_run(1);
    t0 = cyc; pulse(1, 0);
    wait_addr(200, 2000); pulse(1, 0);
    wait_done(1, 2000);
    chk("t4_dur", done_cyc - t0, 2 + 864 + 1);
    drain();
    chk("t4_valid", n_valid, 864); chk("t4_done", n_done, 1);
    // start and again together in IDLE give exactly one run
    clr(); push_run(1);
    pulse(1, 1);
    wait_done(1, 2000);
    drain();
    repeat (1000) tick();
    chk("t4b_done", n_done, 1); chk("t4b_valid", n_valid, 864); chk("t4b_busy", bus.busy, 0);
    // reset mid-run aborts without rd_done, then a fresh run completes
    clr(); cfg(2, 3, 0); push_run(2);
    pulse(1, 0);
    wait_addr(300, 2000);
    rstn = 1'b0;
    tick();
    chk("t5_ctl", {bus.busy, bus.mem_rd_en, bus.rd_done, bus.adc_data_valid, bus.pkt_sop, bus.pkt_eop}, 0);
    chk("t5_addr", bus.mem_rd_addr, 0);
    chk("t5_data", bus.adc_data, 0);
    rstn = 1'b1;
    sb.delete();
    repeat (20) tick();
    chk("t5_nodone", n_done, 0); chk("t5_busy", bus.busy, 0);
    clr(); push_run(2);
    t0 = cyc; pulse(1, 0);
    wait_done(1, 2000);
    chk("t5_dur", done_cyc - t0, 865);
    drain();
    chk("t5_valid", n_valid, 864);
    // shortest packets back-to-back
    clr(); cfg(0, 0, 0); push_run(0);
    t0 = cyc; pulse(1, 0);
    wait_done(1, 2000);
    chk("t6_dur", done_cyc - t0, 865);
    drain();
    chk("t6_valid", n_valid, 864); chk("t6_sop", n_sop, 4); chk("t6_eop", n_eop, 4);
`ifdef PKT_SCHED_FRAME_CNT_EN
    chk("t6_frames", frame_cnt, 4);
    clr(); push_run(0);
    pulse(1, 0);
    chk("t6_frames_clr", frame_cnt, 0);
    wait_done(1, 2000);
    drain();
    chk("t6_frames2", frame_cnt, 4);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
